// File: rtl/alu_arb.sv
// alu_arb: two-requester arbiter/sequencer for a shared 32-bit ALU (req/rsp handshakes, registered ALU operands, captured result)
module alu_arb #(
  parameter logic FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  input  logic [3:0]  req_alucont0,
  input  logic [3:0]  req_alucont1,
  input  logic        req_sltu0,
  input  logic        req_sltu1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_alucont,
  output logic        alu_sltunsigned,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic owner, last_grant, rsp_hs, arb_en, win1, take;
  assign rsp_hs = state == RESP && (owner ? rsp_ready1 : rsp_ready0);
  assign arb_en = state == IDLE || rsp_hs;
  assign win1 = req_valid1 && (!req_valid0 || (FAIR && !last_grant));
  assign req_ready1 = arb_en && win1;
  assign req_ready0 = arb_en && req_valid0 && !win1;
  assign take = req_ready0 || req_ready1;
  assign rsp_valid0 = state == RESP && !owner;
  assign rsp_valid1 = state == RESP && owner;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = take ? EXEC : state == EXEC ? RESP : rsp_hs ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_alucont <= '0;
      alu_sltunsigned <= 1'b0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
      owner <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (take) begin
        alu_a <= req_ready1 ? req_a1 : req_a0;
        alu_b <= req_ready1 ? req_b1 : req_b0;
        alu_alucont <= req_ready1 ? req_alucont1 : req_alucont0;
        alu_sltunsigned <= req_ready1 ? req_sltu1 : req_sltu0;
        owner <= req_ready1;
        last_grant <= req_ready1;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero <= alu_zero;
      end
    end
  end
endmodule
